// File: rtl/life_pkg.sv
// Shared constants and types for the life-grid row writeback path.
package life_pkg;
  localparam int COLS_DEF    = 1280;
  localparam int ROWS_DEF    = 720;
  localparam int IDX_W       = 10;
  localparam int FRAME_CNT_W = 16;
  localparam int ALIVE_W     = 20;

  typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;
  typedef logic [ALIVE_W-1:0]     alive_cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } wb_state_e;
endpackage

// File: rtl/row_fifo2.sv
// Two-entry FIFO holding a row and its index; push is ignored when full, pop when empty.
module row_fifo2 import life_pkg::*; #(
  parameter int W  = COLS_DEF,
  parameter int IW = IDX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic [IW-1:0] push_idx,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [IW-1:0] head_idx,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  data_mem [2];
  logic [IW-1:0] idx_mem  [2];
  logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full      = (cnt_q == 2'd2);
  assign empty     = (cnt_q == 2'd0);
  assign head_data = data_mem[rd_ptr_q];
  assign head_idx  = idx_mem[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    cnt_d    = cnt_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_mem[wr_ptr_q] <= push_data;
      idx_mem[wr_ptr_q]  <= push_idx;
    end
  end
endmodule

// File: rtl/row_writeback.sv
// Buffers computed rows and writes them into a ping-pong frame BRAM, tracking frame progress.
// Optional ROW_WRITEBACK_ALIVE_COUNT_EN adds a per-frame live-cell count output.
module row_writeback import life_pkg::*; #(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLS-1:0]        row_in,
  input  logic [IDX_W-1:0]       row_idx,
  input  logic                   row_valid,
  output logic                   row_ready,
  input  logic                   mem_busy,
  output logic [IDX_W-1:0]       wr_addr,
  output logic [COLS-1:0]        wr_data,
  output logic                   wr_en,
  output logic                   buf_sel,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   seq_err
`ifdef ROW_WRITEBACK_ALIVE_COUNT_EN
  ,
  output logic [ALIVE_W-1:0]     alive_count
`endif
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  wb_state_e               state_q, state_d;
  logic [IDX_W-1:0]        exp_q, exp_d;
  logic                    wr_en_q, wr_en_d;
  logic [IDX_W-1:0]        wr_addr_q, wr_addr_d;
  logic [COLS-1:0]         wr_data_q, wr_data_d;
  logic                    buf_sel_q, buf_sel_d;
  logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic                    seq_err_q, seq_err_d;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [COLS-1:0]         fifo_data, src_data;
  logic [IDX_W-1:0]        fifo_idx, src_idx;
  logic                    accept, fire, in_range, wr, frame_end;

  row_fifo2 #(.W(COLS), .IW(IDX_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (row_in),
    .push_idx  (row_idx),
    .pop       (fifo_pop),
    .head_data (fifo_data),
    .head_idx  (fifo_idx),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign row_ready   = ~fifo_full;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign buf_sel     = buf_sel_q;
  assign frame_count = frame_cnt_q;
  assign seq_err     = seq_err_q;
  assign frame_done  = (state_q == FINISH);

  always_comb begin
    accept    = row_valid & row_ready;
    // An empty FIFO is bypassed so a fresh row reaches the BRAM one cycle after accept.
    src_data  = fifo_empty ? row_in  : fifo_data;
    src_idx   = fifo_empty ? row_idx : fifo_idx;
    fire      = ~mem_busy & (~fifo_empty | accept);
    fifo_push = accept & ~(fifo_empty & ~mem_busy);
    fifo_pop  = fire & ~fifo_empty;
    in_range  = int'(src_idx) < ROWS;
    wr        = fire & in_range;
    frame_end = wr & (state_q == RUN) & (src_idx == LAST_IDX);

    wr_en_d   = wr;
    wr_addr_d = wr ? src_idx  : wr_addr_q;
    wr_data_d = wr ? src_data : wr_data_q;
    seq_err_d = seq_err_q | (fire & ~in_range) | (wr & (src_idx != exp_q));
    exp_d     = exp_q;
    if (wr) exp_d = (src_idx == LAST_IDX) ? '0 : exp_q + IDX_W'(1);

    buf_sel_d   = buf_sel_q;
    frame_cnt_d = frame_cnt_q;
    state_d     = state_q;
    unique case (state_q)
      IDLE:   if (wr && src_idx == '0) state_d = RUN;
      RUN:    if (frame_end) state_d = FINISH;
      FINISH: begin
        buf_sel_d   = ~buf_sel_q;
        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        // Row 0 landing in the FINISH cycle already opens the next frame.
        state_d     = (wr && src_idx == '0) ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      buf_sel_q   <= 1'b0;
      frame_cnt_q <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      buf_sel_q   <= buf_sel_d;
      frame_cnt_q <= frame_cnt_d;
      seq_err_q   <= seq_err_d;
    end
  end

`ifdef ROW_WRITEBACK_ALIVE_COUNT_EN
  logic [ALIVE_W-1:0] acc_q, acc_d, alive_q, alive_d, row_pop;

  assign alive_count = alive_q;

  // The total is latched as the last row is written so it is valid alongside frame_done.
  always_comb begin
    row_pop = '0;
    for (int i = 0; i < COLS; i++) row_pop = row_pop + ALIVE_W'(src_data[i]);
    acc_d   = acc_q;
    alive_d = alive_q;
    if (frame_end) begin
      alive_d = acc_q + row_pop;
      acc_d   = '0;
    end else if (wr) begin
      acc_d   = acc_q + row_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      alive_q <= '0;
    end else begin
      acc_q   <= acc_d;
      alive_q <= alive_d;
    end
  end
`endif
endmodule

// File: tb/tb_row_writeback.sv
// Randomized self-checking bench for row_writeback with a queue-based reference model.
module tb_row_writeback;
  localparam int COLS = 1280;
  localparam int ROWS = 720;
  typedef logic [COLS-1:0] val_t;
  typedef struct {
    logic [9:0] idx;
    val_t       data;
    int         cyc;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [COLS-1:0] row_in = '0;
  logic [9:0]      row_idx = '0;
  logic            row_valid = 1'b0;
  logic            row_ready;
  logic            mem_busy = 1'b0;
  logic [9:0]      wr_addr;
  logic [COLS-1:0] wr_data;
  logic            wr_en, buf_sel, frame_done, seq_err;
  logic [15:0]     frame_count;
`ifdef ROW_WRITEBACK_ALIVE_COUNT_EN
  logic [19:0]     alive_count;
`endif

  row_writeback #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk         (clk),
    .rst         (rst),
    .row_in      (row_in),
    .row_idx     (row_idx),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .mem_busy    (mem_busy),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .buf_sel     (buf_sel),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .seq_err     (seq_err)
`ifdef ROW_WRITEBACK_ALIVE_COUNT_EN
    ,
    .alive_count (alive_count)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0, cyc = 0, acc_cnt = 0, wr_cnt = 0, fd_cnt = 0;
  int   a0, w0, m_next = 0;
  bit   lat_chk = 0, rnd_on = 0, m_err = 0, m_in_frame = 0;
  int   m_frames = 0;
  logic [9:0] last_addr = '0;
  wr_t  exp_q[$];
  wr_t  e;

  task automatic chk(input string tag, input val_t got, input val_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got[191:0]=%0h exp[191:0]=%0h", tag, got[191:0], exp[191:0]);
    end
  endtask

  function automatic val_t rnd_row();
    val_t r;
    for (int i = 0; i < COLS / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: ordered queue of expected writes plus frame/sequence bookkeeping.
  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      wr_cnt++;
      last_addr = wr_addr;
      if (exp_q.size() == 0) chk("spurious_wr", val_t'(wr_en), val_t'(0));
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", val_t'(wr_addr), val_t'(e.idx));
        chk("wr_data", wr_data, e.data);
        if (lat_chk) chk("latency", val_t'(cyc), val_t'(e.cyc + 1));
      end
    end
    if (frame_done) fd_cnt++;
    if (rst) begin
      exp_q.delete();
      m_next = 0; m_err = 0; m_in_frame = 0; m_frames = 0; fd_cnt = 0;
    end else if (row_valid && row_ready) begin
      acc_cnt++;
      if (int'(row_idx) >= ROWS) m_err = 1;
      else begin
        if (int'(row_idx) != m_next) m_err = 1;
        m_next = (int'(row_idx) == ROWS - 1) ? 0 : m_next + 1;
        if (!m_in_frame && row_idx == 10'd0) m_in_frame = 1;
        else if (m_in_frame && int'(row_idx) == ROWS - 1) begin
          m_in_frame = 0;
          m_frames++;
        end
        exp_q.push_back('{row_idx, row_in, cyc});
      end
    end
  end

  task automatic send_row(input int idx, input val_t data);
    bit got = 0;
    row_valid = 1'b1; row_idx = 10'(idx); row_in = data;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk); got = row_ready;
      @(posedge clk); #1;
    end
    row_valid = 1'b0;
    if (!got) chk("send_timeout", val_t'(got), val_t'(1));
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    if (exp_q.size() != 0) chk("drain_timeout", val_t'(exp_q.size()), val_t'(0));
  endtask

  task automatic chk_reset();
    chk("rst_wr_en",   val_t'(wr_en),       val_t'(0));
    chk("rst_wr_addr", val_t'(wr_addr),     val_t'(0));
    chk("rst_wr_data", wr_data,             val_t'(0));
    chk("rst_buf_sel", val_t'(buf_sel),     val_t'(0));
    chk("rst_fdone",   val_t'(frame_done),  val_t'(0));
    chk("rst_fcount",  val_t'(frame_count), val_t'(0));
    chk("rst_seq_err", val_t'(seq_err),     val_t'(0));
    chk("rst_ready",   val_t'(row_ready),   val_t'(1));
`ifdef ROW_WRITEBACK_ALIVE_COUNT_EN
    chk("rst_alive",   val_t'(alive_count), val_t'(0));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; row_valid = 1'b0; mem_busy = 1'b0;
    @(posedge clk); #1;
    chk_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ready_after_rst", val_t'(row_ready), val_t'(1));
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_seq_err"}, val_t'(seq_err),     val_t'(m_err));
    chk({tag, "_fcount"},  val_t'(frame_count), val_t'(m_frames));
    chk({tag, "_buf_sel"}, val_t'(buf_sel),     val_t'(m_frames % 2));
    chk({tag, "_fdone_n"}, val_t'(fd_cnt),      val_t'(m_frames));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt, idx;
    do_reset();

    // Full frame back-to-back, no backpressure.
    lat_chk = 1;
    for (int i = 0; i < ROWS; i++) send_row(i, rnd_row());
    drain();
    lat_chk = 0;
    chk("frame_fd_cnt", val_t'(fd_cnt),      val_t'(1));
    chk("frame_bufsel", val_t'(buf_sel),     val_t'(1));
    chk("frame_fcount", val_t'(frame_count), val_t'(1));
    chk("frame_seqerr", val_t'(seq_err),     val_t'(0));
    chk_state("frame");

    // Memory busy for 5 cycles while 3 rows are offered.
    do_reset();
    a0 = acc_cnt;
    fork
      begin
        mem_busy = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("busy_accepted", val_t'(acc_cnt - a0), val_t'(2));
        chk("busy_ready",    val_t'(row_ready),    val_t'(0));
        mem_busy = 1'b0;
      end
      begin
        send_row(0, rnd_row()); send_row(1, rnd_row()); send_row(2, rnd_row());
      end
    join
    drain();
    chk_state("busy");

    // Sequence gap 0,1,3.
    do_reset();
    send_row(0, rnd_row()); send_row(1, rnd_row());
    drain();
    chk("gap_pre_err", val_t'(seq_err), val_t'(0));
    send_row(3, rnd_row());
    drain();
    chk("gap_err",  val_t'(seq_err),   val_t'(1));
    chk("gap_addr", val_t'(last_addr), val_t'(3));
    chk_state("gap");

    // Out-of-range index is dropped.
    do_reset();
    w0 = wr_cnt;
    send_row(800, rnd_row());
    drain();
    chk("oor_no_wr", val_t'(wr_cnt - w0), val_t'(0));
    chk("oor_err",   val_t'(seq_err),     val_t'(1));
    chk_state("oor");

    // Random backpressure, crossing a frame end, occasional stray indices.
    do_reset();
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          mem_busy = ($urandom_range(0, 2) == 0);
          @(posedge clk); #1;
        end
        mem_busy = 1'b0;
      end
      begin
        nxt = 0;
        for (int i = 0; i < 80; i++) begin
          if (i == 1) nxt = 700;
          idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 799)) : nxt;
          send_row(idx, rnd_row());
          nxt = (idx >= ROWS - 1) ? 0 : idx + 1;
        end
        rnd_on = 0;
      end
    join
    drain();
    chk_state("rand");

    // Reset mid-frame with the FIFO full.
    do_reset();
    for (int i = 0; i <= 300; i++) send_row(i, rnd_row());
    mem_busy = 1'b1;
    send_row(301, rnd_row()); send_row(302, rnd_row());
    chk("mid_full_ready", val_t'(row_ready), val_t'(0));
    w0 = wr_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset();
    rst = 1'b0; mem_busy = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("mid_no_wr", val_t'(wr_cnt - w0), val_t'(0));

`ifdef ROW_WRITEBACK_ALIVE_COUNT_EN
    // All-ones frame: every cell alive.
    do_reset();
    for (int i = 0; i < ROWS; i++) send_row(i, '1);
    begin
      bit seen = 0;
      for (int t = 0; t < 50 && !seen; t++) begin
        @(negedge clk);
        if (frame_done) begin
          seen = 1;
          chk("alive_count", val_t'(alive_count), val_t'(921600));
        end
      end
      if (!seen) chk("alive_fdone_timeout", val_t'(seen), val_t'(1));
    end
    @(posedge clk); #1;
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
